rom_params_streamer: RTL and testbench
======================================

// Module: rom_params_streamer
// PURPOSE
//  Streams pre-loaded weight/parameter words out of one read-only single_port_ram, one word per beat.
//  The RAM is partitioned into NUM_BANKS banks of SIZE words; each run streams one selected bank.
//  The output is a valid/ready stream with a last flag, so downstream MAC/LSTM gate units can stall it.
//  Optional repeat mode re-streams the bank until stopped. Sits between the param RAM and the gate datapath.
// PARAMETERS
//  BIT_WIDTH  8   bits per parameter word
//  SIZE       26  words per bank (>=2)
//  NUM_BANKS  4   number of banks; RAM depth = NUM_BANKS*SIZE
//  ADDR_W     clogb2(NUM_BANKS*SIZE)  RAM address width (derived, do not override)
// PORTS
//  clk        in   1                  clock, all logic on posedge
//  rst        in   1                  reset, asynchronous, active-low
//  start      in   1                  start pulse; sampled only in IDLE
//  bank_sel   in   clogb2(NUM_BANKS)  bank to stream; captured with start
//  repeat_en  in   1                  1: wrap to word 0 of the bank after word SIZE-1
//  stop       in   1                  end a repeat run after the current pass completes
//  out_data   out  BIT_WIDTH          parameter word
//  out_valid  out  1                  out_data valid
//  out_ready  in   1                  consumer accepts beat when out_valid&out_ready
//  out_last   out  1                  marks word SIZE-1 of a pass
//  busy       out  1                  high from accepted start until done
//  done       out  1                  one-cycle pulse after final beat accepted
// BEHAVIOUR
//  Reset: state=IDLE, word counter=0, skid empty, in-flight=0; out_valid/out_last/busy/done=0, out_data=0.
//  FSM IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE: start=1 captures bank_sel, repeat_en; sets busy; idx=0; -> RUN. bank_sel>=NUM_BANKS clamps to NUM_BANKS-1.
//   RUN: issues RAM read at bank*SIZE+idx when (skid count + in-flight) < 2; idx++ per issue.
//    After issuing idx=SIZE-1: if repeat mode and no stop latched, idx wraps to 0, stay RUN; else -> DRAIN.
//   DRAIN: no new reads; when skid empty and in-flight=0 -> IDLE, done=1 for exactly one cycle, busy=0.
//  stop: latched (sticky) while busy; cleared on return to IDLE. Never truncates a pass mid-way.
//  RAM read latency is 1 cycle; the returned word is pushed into the 2-entry skid buffer with last tag.
//  Latency: start accepted at cycle N -> first read at N+1 -> out_valid=1 at N+2 (out_ready high).
//  Throughput: 1 beat/clk with out_ready held high; no bubbles across repeat wrap.
//  Backpressure: out_data/out_last held stable while out_valid=1 and out_ready=0; credit rule prevents overflow.
//  out_last=1 on the beat carrying word SIZE-1 of every pass (each pass in repeat mode).
//  start while busy: ignored. start and done in same cycle: start ignored (FSM still draining).
//  Reset mid-run: asynchronous abort to reset state; no done pulse; in-flight RAM data discarded.
//  RAM write enable tied 0, write data tied 0: the block never writes.
//  Address arithmetic: bank*SIZE computed in ADDR_W bits; idx counter width clogb2(SIZE), never exceeds SIZE-1.
// STRUCTURE
//  Package rom_params_pkg: clogb2 function, FSM state enum (IDLE/RUN/DRAIN), shared BIT_WIDTH default.
//  Sub-module params_skid_buf: 2-entry valid/ready FIFO, {last,data} payload, count output for credit logic.
//  Top holds FSM, idx/bank address generation, in-flight flag, single_port_ram instance.
// TESTING
//  T1 reset: rst=0 async mid-cycle -> all outputs 0, FSM IDLE; release, no activity without start.
//  T2 bank 2, repeat_en=0, out_ready=1: out_valid at N+2, 26 beats = RAM[52..77], last on beat 26, done 1 cycle later.
//  T3 random out_ready (50%) on bank 0: beat order RAM[0..25] exact, data stable while stalled, no drops or duplicates.
//  T4 repeat_en=1 on bank 1, stop after 40 beats: exactly 52 beats, last on beats 26 and 52, then done.
//  T5 start pulsed in RUN and bank_sel=7 in IDLE: mid-run start ignored; sel 7 streams bank 3 (RAM[78..103]).
//  T6 rst asserted after 10 beats: outputs zero at once, no done; new start after release streams from word 0.

Source files
------------

// File: rtl/rom_params_pkg.sv
// Shared types and helpers for the parameter-ROM streamer.
// Holds the FSM state type, the width helper and the power-on contents of the parameter RAM.
package rom_params_pkg;

  localparam int unsigned BitWidthDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Bit count of value: 4 -> 3, 26 -> 5, 104 -> 7.
  // This leaves room to express out-of-range bank selects.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  // Odd multiplier keeps every address's word distinct modulo 256.
  function automatic logic [31:0] param_init_word(input int unsigned addr);
    return 32'(addr * 29 + 7);
  endfunction

endpackage

// File: rtl/rom_params_streamer_if.sv
// Control and output-stream bundle for rom_params_streamer.
// The slave modport is the streamer side; the master modport is the controller/consumer side.
interface rom_params_streamer_if import rom_params_pkg::*; #(
  parameter int unsigned BIT_WIDTH = BitWidthDefault,
  parameter int unsigned NUM_BANKS = 4
) ();
  localparam int unsigned BankW = clogb2(NUM_BANKS);

  logic                 start;
  logic [BankW-1:0]     bank_sel;
  logic                 repeat_en;
  logic                 stop;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, bank_sel, repeat_en, stop, out_ready,
    input  out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, bank_sel, repeat_en, stop, out_ready,
    output out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/params_skid_buf.sv
// Two-entry fall-through FIFO between the RAM read port and the output stream.
// When empty, the incoming word is presented directly so the first beat costs no extra cycle.
module params_skid_buf #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);
  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             empty, push, pop;

  always_comb begin
    empty       = (count_q == 2'd0);
    out_valid_o = !empty || in_valid_i;
    out_data_o  = '0;
    if (!empty) begin
      out_data_o = mem_q[rd_ptr_q];
    end else if (in_valid_i) begin
      out_data_o = in_data_i;
    end
    pop  = !empty && out_ready_i;
    // A word taken straight through while empty is never stored.
    push = in_valid_i && !(empty && out_ready_i);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with a 1-cycle registered read.
// Contents are loaded with the parameter image whenever reset is asserted.
module single_port_ram import rom_params_pkg::*; #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 104,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);
  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             in_range;

  always_comb begin
    in_range = 32'(addr_i) < Depth;
    mem_d    = mem_q;
    rdata_d  = rdata_q;
    if (en_i && in_range) begin
      if (we_i) begin
        mem_d[addr_i] = wdata_i;
      end
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= DataW'(param_init_word(i));
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/rom_params_streamer.sv
// Streams one bank of the parameter RAM as a valid/ready stream with a last flag,
// optionally repeating the bank until stopped.
module rom_params_streamer import rom_params_pkg::*; #(
  parameter int unsigned BIT_WIDTH = BitWidthDefault,
  parameter int unsigned SIZE      = 26,
  parameter int unsigned NUM_BANKS = 4
) (
  input logic                  clk,
  input logic                  rst,
  rom_params_streamer_if.slave bus
);
  localparam int unsigned Depth  = NUM_BANKS * SIZE;
  localparam int unsigned ADDR_W = clogb2(Depth);
  localparam int unsigned IdxW   = clogb2(SIZE);
  localparam int unsigned BankW  = clogb2(NUM_BANKS);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(SIZE - 1);
  localparam logic [BankW-1:0] BankMax = BankW'(NUM_BANKS - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [BankW-1:0]     bank_q, bank_d;
  logic                 rep_q, rep_d;
  logic                 stop_q, stop_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;

  logic                 issue, issue_last, drained, stop_any;
  logic [1:0]           skid_count;
  logic [ADDR_W-1:0]    rd_addr;
  logic [BIT_WIDTH-1:0] ram_rdata;
  logic [BIT_WIDTH:0]   skid_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      bank_q          <= '0;
      rep_q           <= 1'b0;
      stop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      bank_q          <= bank_d;
      rep_q           <= rep_d;
      stop_q          <= stop_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    bank_d          = bank_q;
    rep_d           = rep_q;
    stop_d          = stop_q;
    inflight_d      = issue;
    inflight_last_d = issue_last;
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (bus.start) begin
          state_d = StRun;
          idx_d   = '0;
          rep_d   = bus.repeat_en;
          bank_d  = (32'(bus.bank_sel) >= NUM_BANKS) ? BankMax : bus.bank_sel;
        end
      end
      StRun: begin
        stop_d = stop_any;
        if (issue) begin
          if (idx_q == IdxLast) begin
            if (rep_q && !stop_any) begin
              idx_d = '0;
            end else begin
              state_d = StDrain;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        stop_d = stop_any;
        if (drained) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stop_any = stop_q || bus.stop;
    // Credit: buffered plus in-flight words never exceed the two skid slots.
    issue      = (state_q == StRun) && (({1'b0, skid_count} + {2'b0, inflight_q}) < 3'd2);
    issue_last = issue && (idx_q == IdxLast);
    drained    = (state_q == StDrain) && (skid_count == 2'd0) && !inflight_q;
    rd_addr    = ADDR_W'(bank_q) * ADDR_W'(SIZE) + ADDR_W'(idx_q);
    bus.busy      = (state_q != StIdle) && !drained;
    bus.done      = drained;
    bus.out_data  = skid_out[BIT_WIDTH-1:0];
    bus.out_last  = skid_out[BIT_WIDTH];
  end

  single_port_ram #(
    .DataW (BIT_WIDTH),
    .Depth (Depth),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (issue),
    .we_i    (1'b0),
    .addr_i  (rd_addr),
    .wdata_i ('0),
    .rdata_o (ram_rdata)
  );

  params_skid_buf #(
    .Width (BIT_WIDTH + 1)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst),
    .in_valid_i  (inflight_q),
    .in_data_i   ({inflight_last_q, ram_rdata}),
    .out_valid_o (bus.out_valid),
    .out_data_o  (skid_out),
    .out_ready_i (bus.out_ready),
    .count_o     (skid_count)
  );
endmodule

// File: tb/tb_rom_params_streamer.sv
// Scoreboard bench for rom_params_streamer: expected beats are queued per run from a
// plain-arithmetic model of the parameter image; a monitor pops and compares each accepted beat.
module tb_rom_params_streamer;
  localparam int unsigned BW        = 8;
  localparam int unsigned SIZE      = 26;
  localparam int unsigned NUM_BANKS = 4;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;
  int cyc;
  int start_cyc;
  int first_valid_cyc;
  int last_accept_cyc;
  int accept_count;
  bit rand_ready;
  bit stall_prev;
  logic [BW-1:0] hold_data;
  logic          hold_last;
  logic [BW:0]   exp_q[$];

  rom_params_streamer_if #(.BIT_WIDTH(BW), .NUM_BANKS(NUM_BANKS)) bus ();

  rom_params_streamer #(
    .BIT_WIDTH (BW),
    .SIZE      (SIZE),
    .NUM_BANKS (NUM_BANKS)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Expected word: address a holds (a*29 + 7) mod 256; last flag on word SIZE-1 of a pass.
  function automatic logic [BW:0] model_word(input int bank, input int i);
    int a;
    logic [BW-1:0] d;
    a = bank * int'(SIZE) + i;
    d = BW'((a * 29 + 7) % 256);
    return {(i == int'(SIZE) - 1), d};
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on every handshake, plus hold-stable check while stalled.
  initial begin
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          vectors++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== hold_data || bus.out_last !== hold_last)
          begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                     cyc, bus.out_valid, bus.out_data, bus.out_last, hold_data, hold_last);
          end
        end
        if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat cyc=%0d got d=%0h l=%0b want no beat",
                     cyc, bus.out_data, bus.out_last);
          end else begin
            logic [BW:0] e;
            e = exp_q.pop_front();
            if ({bus.out_last, bus.out_data} !== e) begin
              miscompares++;
              $display("FAIL beat cyc=%0d got d=%0h l=%0b want d=%0h l=%0b",
                       cyc, bus.out_data, bus.out_last, e[BW-1:0], e[BW]);
            end
          end
          accept_count++;
          last_accept_cyc = cyc;
        end
        stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        hold_data  = bus.out_data;
        hold_last  = bus.out_last;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, int'(bus.out_valid), 0);
    check({name, "_last"},  int'(bus.out_last),  0);
    check({name, "_busy"},  int'(bus.busy),      0);
    check({name, "_done"},  int'(bus.done),      0);
    check({name, "_data"},  int'(bus.out_data),  0);
  endtask

  task automatic start_pulse(input logic [2:0] sel, input bit rep);
    @(posedge clk);
    #1;
    start_cyc       = cyc;
    accept_count    = 0;
    first_valid_cyc = -1;
    bus.start       = 1'b1;
    bus.bank_sel    = sel;
    bus.repeat_en   = rep;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic run_case(input string name, input logic [2:0] sel, input bit rep,
                          input int passes, input int stop_after, input int midstart_after,
                          input bit done_start, input bit full_rate);
    int  eff, total, done_cyc;
    bit  got, stop_sent, mid_sent;
    eff   = (int'(sel) >= int'(NUM_BANKS)) ? int'(NUM_BANKS) - 1 : int'(sel);
    total = passes * int'(SIZE);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < int'(SIZE); i++) exp_q.push_back(model_word(eff, i));
    start_pulse(sel, rep);
    got = 0; stop_sent = 0; mid_sent = 0; done_cyc = 0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        got      = 1;
        done_cyc = cyc;
      end else begin
        if (stop_after > 0 && !stop_sent && accept_count >= stop_after) begin
          bus.stop  = 1'b1;
          stop_sent = 1;
        end
        if (midstart_after > 0 && !mid_sent && accept_count >= midstart_after) begin
          bus.start    = 1'b1;
          bus.bank_sel = 3'd0;
          mid_sent     = 1;
        end
      end
    end
    check({name, "_done_seen"}, int'(got), 1);
    if (!got) begin
      exp_q.delete();
      return;
    end
    check({name, "_beats"}, accept_count, total);
    check({name, "_done_time"}, done_cyc, last_accept_cyc + 1);
    check({name, "_first_valid"}, first_valid_cyc, start_cyc + 2);
    if (full_rate) check({name, "_no_bubbles"}, last_accept_cyc - first_valid_cyc, total - 1);
    if (done_start) begin
      bus.start    = 1'b1;
      bus.bank_sel = 3'd1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_done_pulse"}, int'(bus.done), 0);
    check({name, "_busy_off"}, int'(bus.busy), 0);
    repeat (4) @(negedge clk);
    check({name, "_idle_busy"}, int'(bus.busy), 0);
    check({name, "_idle_valid"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rand_ready    = 0;
    bus.start     = 1'b0;
    bus.bank_sel  = '0;
    bus.repeat_en = 1'b0;
    bus.stop      = 1'b0;
    rst_n         = 1'b0;
    first_valid_cyc = -1;
    last_accept_cyc = 0;
    accept_count    = 0;

    // T1: reset state, then quiet idle without start.
    #13;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle_no_start");

    // T2: bank 2, single pass, full rate.
    run_case("t2_bank2", 3'd2, 1'b0, 1, 0, 0, 1'b0, 1'b1);

    // T3: bank 0 under random backpressure.
    rand_ready = 1;
    run_case("t3_bank0_bp", 3'd0, 1'b0, 1, 0, 0, 1'b0, 1'b0);
    rand_ready = 0;

    // T4: repeat on bank 1, stop after 40 beats -> two whole passes.
    run_case("t4_repeat", 3'd1, 1'b1, 2, 40, 0, 1'b0, 1'b1);

    // T5: start pulsed mid-run and on the done cycle; sel 7 clamps to bank 3.
    run_case("t5_clamp", 3'd7, 1'b0, 1, 0, 5, 1'b1, 1'b1);

    // Random bank selection with random backpressure.
    rand_ready = 1;
    for (int k = 0; k < 3; k++) run_case("rand", 3'($urandom_range(0, 7)), 1'b0, 1, 0, 0,
                                         1'b0, 1'b0);
    rand_ready = 0;

    // T6: asynchronous reset after 10 beats, then a fresh run from word 0.
    for (int i = 0; i < int'(SIZE); i++) exp_q.push_back(model_word(2, i));
    start_pulse(3'd2, 1'b0);
    for (int c = 0; c < 200 && accept_count < 10; c++) @(negedge clk);
    check("t6_reached_10", int'(accept_count >= 10), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_hits;
      done_hits = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.done === 1'b1 || bus.busy === 1'b1) done_hits++;
      end
      check("t6_no_done_after_reset", done_hits, 0);
    end
    run_case("t6_restart", 3'd2, 1'b0, 1, 0, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
